ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits alongside the keyboard press driver on the same PS2_CLK/PS2_DAT pair and drives both lines open-drain through top-level tri-states.
- Performs the inhibit/request-to-send sequence, shifts data, parity and stop on device-generated clock edges, then checks the device ACK bit.
- Reports completion and ACK/NAK/timeout status to the command logic.

---
 rtl/ps2_host_tx_if.sv | 28 ++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the keyboard command logic and ps2_host_tx.
// master = command logic, slave = transmitter.
interface ps2_host_tx_if;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output cmd_valid,
        output cmd_byte,
        input  cmd_ready,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  cmd_valid,
        input  cmd_byte,
        output cmd_ready,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clk/dat enables).
// Define PS2_HOST_TX_RETRY_EN for one automatic retry on NAK/timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 6000,
    parameter int START_HOLD_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave cmd,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, ACK, RELEASE, DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_cnt, bit_n;
    logic [8:0]    data, data_n;
    logic [8:0]    shreg, shreg_n;
    logic          err, err_n;
    logic          clk_oe_n, dat_oe_n;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic          clk_s, dat_s, fall;
    logic          on_bus, tmo, to_done;
`ifdef PS2_HOST_TX_RETRY_EN
    logic          retry, retry_n;
`endif

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fall  = clk_prev & ~clk_s;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = ~cmd.cmd_ready;
    assign cmd.done      = (state == DONE);
    assign cmd.error     = (state == DONE) & err;

    assign on_bus = (state == SEND) || (state == ACK) || (state == RELEASE);
    assign tmo    = on_bus && !fall && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            data       <= '0;
            shreg      <= '0;
            err        <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_n;
            data       <= data_n;
            shreg      <= shreg_n;
            err        <= err_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
`ifdef PS2_HOST_TX_RETRY_EN
            retry      <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_cnt;
        data_n   = data;
        shreg_n  = shreg;
        err_n    = err;
        clk_oe_n = ps2_clk_oe;
        dat_oe_n = ps2_dat_oe;
        to_done  = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_n  = retry;
`endif
        // Inter-edge watchdog restarts on every device clock fall
        if (on_bus) begin
            cnt_n = fall ? '0 : cnt + CW'(1);
        end

        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    data_n   = {~^cmd.cmd_byte, cmd.cmd_byte};
                    err_n    = 1'b0;
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    dat_oe_n = 1'b0;
                    state_n  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_n  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_n    = '0;
                    dat_oe_n = 1'b1;
                    state_n  = START;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            START: begin
                if (cnt == CW'(START_HOLD_CYCLES - 1)) begin
                    cnt_n    = '0;
                    bit_n    = '0;
                    shreg_n  = data;
                    clk_oe_n = 1'b0;
                    state_n  = SEND;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SEND: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        dat_oe_n = 1'b0;
                        state_n  = ACK;
                    end else begin
                        dat_oe_n = ~shreg[0];
                        shreg_n  = shreg >> 1;
                        bit_n    = bit_cnt + 4'd1;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    err_n   = dat_s;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_s && dat_s) begin
                    to_done = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (tmo) begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            err_n    = 1'b1;
            to_done  = 1'b1;
        end

        if (to_done) begin
            state_n = DONE;
`ifdef PS2_HOST_TX_RETRY_EN
            // First failure silently restarts the frame with the same byte
            if (err_n && !retry) begin
                state_n  = INHIBIT;
                retry_n  = 1'b1;
                err_n    = 1'b0;
                cnt_n    = '0;
                clk_oe_n = 1'b1;
                dat_oe_n = 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Honours PS2_HOST_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;
    localparam int INH  = 10;
    localparam int SH   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_dat = ~(ps2_dat_oe | dev_dat_low);

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int clk_oe_cnt = 0;
    int done_cnt = 0;
    int dev_falls = 0;
    int fall_cyc = 0;

    ps2_host_tx_if cmd ();

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .START_HOLD_CYCLES(SH),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .ps2_clk_in(ps2_clk),
        .ps2_dat_in(ps2_dat),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;
        if (cmd.done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Device: waits for request-to-send, then clocks 40-cycle periods.
    task automatic device(input int stop_after, input bit ack,
                          output logic [9:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (!(ps2_clk && !ps2_dat) && w < 2000) begin
            @(posedge clock);
            w++;
        end
        if (w >= 2000) begin
            check("dev_rts_seen", 0, 1);
            return;
        end
        for (int k = 1; k <= 11 && k <= stop_after; k++) begin
            repeat (HALF) @(posedge clock);
            if (k == 11) dev_dat_low = ack;
            @(negedge clock);
            dev_clk_low = 1'b1;
            dev_falls++;
            fall_cyc = cyc;
            repeat (HALF) @(posedge clock);
            if (k <= 10) bits[k-1] = ps2_dat;
            @(negedge clock);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_done(output bit seen);
        int w;
        seen = 1'b0;
        w = 0;
        while (!seen && w < 1000) begin
            @(posedge clock);
            #1;
            seen = cmd.done;
            w++;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit ack, input int stop_after);
        logic [9:0] bits, exp, mask;
        int attempts, base_oe, base_done, nb;
        bit fail, seen;
        fail = !ack || (stop_after < 11);
        attempts = (RETRY && fail) ? 2 : 1;
        exp = {1'b1, ~^b, b};
        nb = (stop_after > 10) ? 10 : stop_after;
        mask = 10'((1 << nb) - 1);
        base_oe = clk_oe_cnt;
        base_done = done_cnt;
        @(negedge clock);
        check("ready_idle", cmd.cmd_ready, 1);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_byte = b;
        @(posedge clock);
        #1;
        cmd.cmd_valid = 1'b0;
        check("busy_after_accept", {cmd.cmd_ready, cmd.busy}, 2'b01);
        for (int a = 0; a < attempts; a++) begin
            device(stop_after, ack, bits);
            check("frame_bits", bits & mask, exp & mask);
        end
        wait_done(seen);
        check("done_seen", seen, 1);
        if (seen) begin
            check("error", cmd.error, fail);
            check("oe_at_done", {ps2_clk_oe, ps2_dat_oe}, 0);
            if (stop_after < 11) check("timeout_latency", cyc - fall_cyc, TO + 3);
            @(posedge clock);
            #1;
            check("ready_after_done", {cmd.cmd_ready, cmd.done}, 2'b10);
        end
        check("done_pulses", done_cnt - base_done, 1);
        check("clk_oe_cycles", clk_oe_cnt - base_oe, 14 * attempts);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] rb;
        int w, base, base_done, ready_hi, st;
        bit seen, rack;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_byte = 8'hAA;
        repeat (4) @(posedge clock);
        #1;
        check("rst_ready", cmd.cmd_ready, 1);
        check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_done_err", {cmd.done, cmd.error}, 0);
        @(negedge clock);
        cmd.cmd_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);

        xfer(8'hED, 1'b1, 11);
        xfer(8'h01, 1'b1, 11);
        xfer(8'hFF, 1'b0, 11);
        xfer(8'h00, 1'b1, 5);

        // Reset while dat_oe is driving a 0 data bit at fall 4
        base = dev_falls;
        base_done = done_cnt;
        @(negedge clock);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_byte = 8'hF0;
        @(posedge clock);
        #1;
        cmd.cmd_valid = 1'b0;
        fork
            device(4, 1'b1, bits);
            begin
                w = 0;
                while (dev_falls < base + 4 && w < 3000) begin
                    @(posedge clock);
                    w++;
                end
                check("rst_mid_reach_fall4", dev_falls - base, 4);
                repeat (5) @(posedge clock);
                #1;
                check("pre_rst_dat_oe", ps2_dat_oe, 1);
                @(negedge clock);
                reset = 1'b1;
                @(posedge clock);
                #1;
                check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
                check("rst_mid_ready", cmd.cmd_ready, 1);
                @(negedge clock);
                reset = 1'b0;
            end
        join
        repeat (300) @(posedge clock);
        #1;
        check("rst_mid_no_done", done_cnt - base_done, 0);
        xfer(8'hF4, 1'b1, 11);

        // cmd_valid held high with a second byte queued
        @(negedge clock);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_byte = 8'h3C;
        @(posedge clock);
        #1;
        cmd.cmd_byte = 8'hA5;
        ready_hi = 0;
        fork
            begin
                device(11, 1'b1, bits);
                check("q1_frame", bits, {1'b1, ~^8'h3C, 8'h3C});
            end
            begin
                w = 0;
                while (!cmd.done && w < 3000) begin
                    if (cmd.cmd_ready) ready_hi++;
                    @(posedge clock);
                    #1;
                    w++;
                end
            end
        join
        check("q1_done", cmd.done, 1);
        check("q1_ready_low", ready_hi, 0);
        @(posedge clock);
        #1;
        check("q1_ready_after", {cmd.cmd_ready, cmd.done}, 2'b10);
        @(posedge clock);
        #1;
        check("q2_accepted", cmd.cmd_ready, 0);
        cmd.cmd_valid = 1'b0;
        device(11, 1'b1, bits);
        check("q2_frame", bits, {1'b1, ~^8'hA5, 8'hA5});
        wait_done(seen);
        check("q2_done", seen, 1);
        check("q2_error", cmd.error, 0);
        repeat (2) @(posedge clock);

        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rack = ($urandom % 4) != 0;
            st = (($urandom % 5) == 0) ? int'($urandom_range(1, 10)) : 11;
            xfer(rb, rack, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
